// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the nibble-CPU fetch stage: FSM encoding, default
// field widths and the boot program image compiled into the ROM.
package fetch_unit_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_INSTR_W = 4;
  localparam int DEF_OPER_W  = 4;
  localparam int DEF_PROG_W  = DEF_INSTR_W + DEF_OPER_W;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_FETCH_ENC = 2'd1;
  localparam logic [1:0] ST_LATCH_ENC = 2'd2;
  localparam logic [1:0] ST_EXEC_ENC  = 2'd3;

  typedef enum logic [1:0] {
    FS_IDLE  = ST_IDLE_ENC,
    FS_FETCH = ST_FETCH_ENC,
    FS_LATCH = ST_LATCH_ENC,
    FS_EXEC  = ST_EXEC_ENC
  } fetch_state_t;

  function automatic int prog_width(input int instr_w, input int oper_w);
    return instr_w + oper_w;
  endfunction

  // Contents of memory.list; the last ROM location holds the wrap-test word.
  function automatic logic [DEF_PROG_W-1:0] boot_word(input logic [31:0] addr,
                                                      input logic        is_last);
    logic [DEF_PROG_W-1:0] w;
    w = '0;
    if (is_last) begin
      w = 8'hF0;
    end else begin
      case (addr)
        32'd0:   w = 8'h1A;
        32'd1:   w = 8'h2B;
        32'd2:   w = 8'h3C;
        default: w = 8'h00;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/fetch_unit_program_rom.sv
// Program ROM with a registered read port (one cycle from address to data).
module program_rom
  import fetch_unit_pkg::*;
#(
  parameter int    ADDR_W   = DEF_ADDR_W,
  parameter int    PROG_W   = DEF_PROG_W,
  parameter string ROM_FILE = "memory.list"
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [PROG_W-1:0] q
);

  // The memory.list image is compiled in, so no file is needed at elaboration;
  // any other image name yields an erased (all-zero) ROM.
  localparam bit BOOT_IMAGE = (ROM_FILE == "memory.list") || (ROM_FILE == "");

  always_ff @(posedge clk) begin
    if (BOOT_IMAGE) q <= PROG_W'(boot_word(32'(addr), &addr));
    else            q <= '0;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: loadable PC, synchronous program ROM, fetch register and the
// IDLE/FETCH/LATCH/EXEC sequencer that hands words to the decoder.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int    ADDR_W   = DEF_ADDR_W,
  parameter int    INSTR_W  = DEF_INSTR_W,
  parameter int    OPER_W   = DEF_OPER_W,
  parameter string ROM_FILE = "memory.list"
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_pc,
  input  logic [ADDR_W-1:0]          load_addr,
  input  logic                       pc_en,
  input  logic                       fetch_en,
  input  logic                       stall,
  output logic [ADDR_W-1:0]          pc,
  output logic [INSTR_W+OPER_W-1:0]  program_byte,
  output logic [INSTR_W-1:0]         instruccion,
  output logic [OPER_W-1:0]          operando,
  output logic                       valid,
  output logic                       wrap
);

  localparam int PROG_W = prog_width(INSTR_W, OPER_W);

  fetch_state_t      state;
  logic [PROG_W-1:0] rom_q;

  program_rom #(
    .ADDR_W   (ADDR_W),
    .PROG_W   (PROG_W),
    .ROM_FILE (ROM_FILE)
  ) u_rom (
    .clk  (clk),
    .addr (pc),
    .q    (rom_q)
  );

  assign instruccion = program_byte[PROG_W-1 -: INSTR_W];
  assign operando    = program_byte[OPER_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= FS_IDLE;
      pc           <= '0;
      program_byte <= '0;
      valid        <= 1'b0;
      wrap         <= 1'b0;
    end else begin
      wrap <= 1'b0;
      // A reload restarts the fetch at the new address; whatever rom_q holds
      // now belongs to the old PC and is never latched.
      if (load_pc) begin
        pc    <= load_addr;
        valid <= 1'b0;
        state <= FS_FETCH;
      end else begin
        case (state)
          FS_IDLE: begin
            if (fetch_en) state <= FS_FETCH;
          end
          FS_FETCH: begin
            state <= FS_LATCH;
          end
          FS_LATCH: begin
            program_byte <= rom_q;
            if (pc_en) begin
              pc   <= pc + 1'b1;
              wrap <= &pc;
            end
            valid <= 1'b1;
            state <= FS_EXEC;
          end
          FS_EXEC: begin
            if (!stall) begin
              valid <= 1'b0;
              state <= fetch_en ? FS_FETCH : FS_IDLE;
            end
          end
          default: state <= FS_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: expected words are queued when a fetch is
// requested and compared when the DUT raises valid.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_pc;
  logic [11:0] load_addr;
  logic        pc_en;
  logic        fetch_en;
  logic        stall;
  logic [11:0] pc;
  logic [7:0]  program_byte;
  logic [3:0]  instruccion;
  logic [3:0]  operando;
  logic        valid;
  logic        wrap;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .load_pc      (load_pc),
    .load_addr    (load_addr),
    .pc_en        (pc_en),
    .fetch_en     (fetch_en),
    .stall        (stall),
    .pc           (pc),
    .program_byte (program_byte),
    .instruccion  (instruccion),
    .operando     (operando),
    .valid        (valid),
    .wrap         (wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_model(input logic [11:0] a);
    case (a)
      12'h000: return 8'h1A;
      12'h001: return 8'h2B;
      12'h002: return 8'h3C;
      12'hFFF: return 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; load_pc = 1'b0; load_addr = '0;
    pc_en = 1'b0; fetch_en = 1'b0; stall = 1'b0;
    repeat (2) step();
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL reset_pc: got %h want 000", pc); end
    total++; if (program_byte !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", program_byte); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
  endtask

  task automatic test_first_fetch();
    logic [7:0] exp;
    #4 reset = 1'b1;
    fetch_en = 1'b1; pc_en = 1'b1;
    exp_q.push_back(rom_model(12'h000));
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL lat_edge1_valid: got %b want 0", valid); end
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL lat_edge2_valid: got %b want 0", valid); end
    step();
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL lat_edge3_valid: got %b want 1", valid); end
    exp = exp_q.pop_front();
    total++; if (program_byte !== exp) begin bad++; $display("FAIL first_word: got %h want %h", program_byte, exp); end
    total++; if (instruccion !== exp[7:4]) begin bad++; $display("FAIL first_instr: got %h want %h", instruccion, exp[7:4]); end
    total++; if (operando !== exp[3:0]) begin bad++; $display("FAIL first_oper: got %h want %h", operando, exp[3:0]); end
    total++; if (pc !== 12'h001) begin bad++; $display("FAIL first_pc: got %h want 001", pc); end
    step();
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL first_valid_pulse: got %b want 0", valid); end
  endtask

  task automatic test_continuous();
    bit ok;
    logic [7:0] exp;
    for (int i = 1; i < 3; i++) begin
      exp_q.push_back(rom_model(12'(i)));
      wait_valid(ok);
      total++; if (!ok) begin bad++; $display("FAIL cont_timeout[%0d]: got no valid want valid", i); end
      exp = exp_q.pop_front();
      total++; if (program_byte !== exp) begin bad++; $display("FAIL cont_word[%0d]: got %h want %h", i, program_byte, exp); end
      total++; if (pc !== 12'(i + 1)) begin bad++; $display("FAIL cont_pc[%0d]: got %h want %h", i, pc, 12'(i + 1)); end
      if (i == 2) fetch_en = 1'b0;
      step();
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL cont_valid_pulse[%0d]: got %b want 0", i, valid); end
    end
  endtask

  task automatic test_stall();
    bit ok;
    logic [7:0] exp;
    load_pc = 1'b1; load_addr = 12'h001;
    step();
    load_pc = 1'b0;
    total++; if (pc !== 12'h001) begin bad++; $display("FAIL stall_load_pc: got %h want 001", pc); end
    fetch_en = 1'b1;
    exp_q.push_back(rom_model(12'h001));
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL stall_timeout: got no valid want valid"); end
    exp = exp_q.pop_front();
    stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, valid); end
      total++; if (program_byte !== exp) begin bad++; $display("FAIL stall_word[%0d]: got %h want %h", c, program_byte, exp); end
      total++; if (pc !== 12'h002) begin bad++; $display("FAIL stall_pc[%0d]: got %h want 002", c, pc); end
    end
    load_pc = 1'b1; load_addr = 12'h002;
    step();
    load_pc = 1'b0;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL stall_abort_valid: got %b want 0", valid); end
    total++; if (program_byte !== exp) begin bad++; $display("FAIL stall_abort_word: got %h want %h", program_byte, exp); end
    stall = 1'b0;
    exp_q.push_back(rom_model(12'h002));
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_refetch_timeout: got no valid want valid"); end
    exp = exp_q.pop_front();
    total++; if (program_byte !== exp) begin bad++; $display("FAIL abort_refetch_word: got %h want %h", program_byte, exp); end
    total++; if (pc !== 12'h003) begin bad++; $display("FAIL abort_refetch_pc: got %h want 003", pc); end
    fetch_en = 1'b0;
    step();
  endtask

  task automatic test_reload_wrap();
    bit ok;
    logic [7:0] exp;
    load_pc = 1'b1; load_addr = 12'h000;
    step();
    load_addr = 12'hFFF;
    step();
    load_pc = 1'b0;
    total++; if (pc !== 12'hFFF) begin bad++; $display("FAIL reload_pc: got %h want fff", pc); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reload_valid: got %b want 0", valid); end
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reload_no_wrap: got %b want 0", wrap); end
    fetch_en = 1'b1; pc_en = 1'b1;
    exp_q.push_back(rom_model(12'hFFF));
    wait_valid(ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got no valid want valid"); end
    exp = exp_q.pop_front();
    total++; if (program_byte !== exp) begin bad++; $display("FAIL wrap_word: got %h want %h", program_byte, exp); end
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL wrap_pc: got %h want 000", pc); end
    total++; if (wrap !== 1'b1) begin bad++; $display("FAIL wrap_pulse: got %b want 1", wrap); end
    fetch_en = 1'b0;
    step();
    total++; if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_one_cycle: got %b want 0", wrap); end
  endtask

  task automatic test_pc_hold();
    bit ok;
    logic [7:0] exp;
    pc_en = 1'b0; fetch_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(rom_model(12'h000));
      wait_valid(ok);
      total++; if (!ok) begin bad++; $display("FAIL hold_timeout[%0d]: got no valid want valid", i); end
      exp = exp_q.pop_front();
      total++; if (program_byte !== exp) begin bad++; $display("FAIL hold_word[%0d]: got %h want %h", i, program_byte, exp); end
      total++; if (pc !== 12'h000) begin bad++; $display("FAIL hold_pc[%0d]: got %h want 000", i, pc); end
    end
    fetch_en = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    pc_en = 1'b1;
    load_pc = 1'b1; load_addr = 12'hFFF;
    step();
    load_pc = 1'b0;
    step();
    #3 reset = 1'b0;
    #1;
    total++; if (pc !== 12'h000) begin bad++; $display("FAIL areset_pc: got %h want 000", pc); end
    total++; if (program_byte !== 8'h00) begin bad++; $display("FAIL areset_byte: got %h want 00", program_byte); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL areset_valid: got %b want 0", valid); end
    #3 reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (wrap !== 1'b0) begin bad++; $display("FAIL areset_wrap[%0d]: got %b want 0", c, wrap); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL areset_idle[%0d]: got %b want 0", c, valid); end
      total++; if (pc !== 12'h000) begin bad++; $display("FAIL areset_pc_hold[%0d]: got %h want 000", c, pc); end
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_continuous();
    test_stall();
    test_reload_wrap();
    test_pc_hold();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
